// File: rtl/systolic_feeder.sv
// systolic_feeder: producer side of the systolic array row/column inputs.
// Takes one A column and one B row per reduction step over a joint
// valid/ready handshake, skews lane i by i steps, then flushes zeros until
// every PE has its final sum and pulses done.
// Element width comes from the global `DATA_WIDTH define.
// Optional feature macro: SYSTOLIC_FEEDER_PERF_EN adds the stall_cnt output.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module systolic_feeder #(
    parameter int TILE_DIM = 64,
    parameter int K_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [K_W-1:0]                   k_len,
    input  logic                             a_valid,
    output logic                             a_ready,
    input  logic [TILE_DIM*`DATA_WIDTH-1:0]  a_col,
    input  logic                             b_valid,
    output logic                             b_ready,
    input  logic [TILE_DIM*`DATA_WIDTH-1:0]  b_row,
    output logic [TILE_DIM*`DATA_WIDTH-1:0]  in_row,
    output logic [TILE_DIM*`DATA_WIDTH-1:0]  in_col,
    output logic                             enb,
    output logic                             acc_clr,
    output logic                             busy,
`ifdef SYSTOLIC_FEEDER_PERF_EN
    output logic                             done,
    output logic [31:0]                      stall_cnt
`else
    output logic                             done
`endif
);

    localparam int DW        = `DATA_WIDTH;
    // Zero-flush length: enough advances for the last element of the last
    // lane to cross the whole array diagonally.
    localparam int DRAIN_LEN = 3 * TILE_DIM - 2;
    localparam int DCW       = $clog2(DRAIN_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_reg;
    logic [K_W-1:0] k_reg;
    logic [K_W-1:0] step_cnt_reg;
    logic [DCW-1:0] drain_cnt_reg;
    logic           acc_clr_reg;
    logic           done_reg;
    logic           enb_reg;

    logic           accept;
    logic           advance;

    // Joint handshake: both operands are consumed together or not at all.
    assign accept  = (state_reg == S_STREAM) & a_valid & b_valid;
    assign advance = accept | (state_reg == S_DRAIN);

    assign a_ready = accept;
    assign b_ready = accept;
    assign enb     = enb_reg;
    assign acc_clr = acc_clr_reg;
    assign done    = done_reg;
    assign busy    = (state_reg != S_IDLE);

    // Job sequencer: step/drain counting and the registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            k_reg         <= '0;
            step_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            acc_clr_reg   <= 1'b0;
            done_reg      <= 1'b0;
            enb_reg       <= 1'b0;
        end else begin
            acc_clr_reg <= 1'b0;
            done_reg    <= 1'b0;
            enb_reg     <= advance;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        k_reg <= k_len;
                        if (k_len != '0) begin
                            state_reg   <= S_CLEAR;
                            acc_clr_reg <= 1'b1;
                        end else begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_reg    <= S_STREAM;
                    step_cnt_reg <= '0;
                end
                S_STREAM: begin
                    if (accept) begin
                        if (step_cnt_reg == k_reg - K_W'(1)) begin
                            state_reg     <= S_DRAIN;
                            drain_cnt_reg <= '0;
                        end else begin
                            step_cnt_reg <= step_cnt_reg + K_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_reg == DCW'(DRAIN_LEN - 1)) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + DCW'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Per-lane skew chains; lane 0 sits at the MSB end of each vector.
    for (genvar gi = 0; gi < TILE_DIM; gi++) begin : g_lane
        localparam int LO = (TILE_DIM - 1 - gi) * DW;

        logic [DW-1:0] a_chain_reg [0:gi];
        logic [DW-1:0] b_chain_reg [0:gi];
        logic [DW-1:0] a_next;
        logic [DW-1:0] b_next;

        // Fresh operands while streaming, zeros while flushing.
        assign a_next = (state_reg == S_STREAM) ? a_col[LO +: DW] : '0;
        assign b_next = (state_reg == S_STREAM) ? b_row[LO +: DW] : '0;

        // Shift the (gi+1)-deep chain on every advance, hold otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d <= gi; d++) begin
                    a_chain_reg[d] <= '0;
                    b_chain_reg[d] <= '0;
                end
            end else if (advance) begin
                a_chain_reg[0] <= a_next;
                b_chain_reg[0] <= b_next;
                for (int d = 1; d <= gi; d++) begin
                    a_chain_reg[d] <= a_chain_reg[d-1];
                    b_chain_reg[d] <= b_chain_reg[d-1];
                end
            end
        end

        assign in_row[LO +: DW] = a_chain_reg[gi];
        assign in_col[LO +: DW] = b_chain_reg[gi];
    end

`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [31:0] stall_cnt_reg;

    // Saturating count of streaming cycles where the handshake did not fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == S_IDLE) && start && (k_len != '0)) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == S_STREAM) && !accept && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
